// File: rtl/msf_pkg.sv
// msf_pkg: shared constants and types for the MSF frame validator.
//   - A-bit ranges for the BCD fields, minute-identifier and parity-bit positions
//   - err_code_t: rejection causes reported on err_code_o
//   - state_t:    frame tracking states
package msf_pkg;

  localparam int YEAR_LO   = 17;
  localparam int YEAR_HI   = 24;
  localparam int DATE_LO   = 25;  // month and day of month
  localparam int DATE_HI   = 35;
  localparam int DOW_LO    = 36;
  localparam int DOW_HI    = 38;
  localparam int TIME_LO   = 39;  // hour and minute
  localparam int TIME_HI   = 51;
  localparam int MARKER_LO = 52;
  localparam int MARKER_HI = 59;
  localparam int PAR_LO    = 54;  // 54B..57B carry odd parity for year/date/dow/time
  localparam int PAR_HI    = 57;

  // 52A..59A = 0,1,1,1,1,1,1,0 ; bit 7 holds 52A, bit 0 holds 59A
  localparam logic [7:0] MARKER_PATTERN = 8'b0111_1110;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_SHORT    = 3'd1,
    ERR_LONG     = 3'd2,
    ERR_MARKER   = 3'd3,
    ERR_PAR_YEAR = 3'd4,
    ERR_PAR_DATE = 3'd5,
    ERR_PAR_DOW  = 3'd6,
    ERR_PAR_TIME = 3'd7
  } err_code_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    ARMED   = 2'd2
  } state_t;

  function automatic logic in_range(input logic [5:0] s, input int lo, input int hi);
    return (int'(s) >= lo) && (int'(s) <= hi);
  endfunction

endpackage

// File: rtl/msf_parity_acc.sv
// msf_parity_acc: four range-gated XOR accumulators over the A bits plus
// capture of the parity bits 54B..57B.
//   clk, rst      : clock, synchronous active-high reset
//   sec           : second index of the symbol presented this cycle
//   a, b          : A and B bits of that symbol
//   valid         : accumulate this symbol
//   clear         : start of a new frame (wins over valid)
//   year_ok .. time_ok : odd parity over field + its parity bit holds
module msf_parity_acc
  import msf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic       a,
  input  logic       b,
  input  logic       valid,
  input  logic       clear,
  output logic       year_ok,
  output logic       date_ok,
  output logic       dow_ok,
  output logic       time_ok
);

  logic       year_acc_reg;
  logic       date_acc_reg;
  logic       dow_acc_reg;
  logic       time_acc_reg;
  logic [3:0] b_cap_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      year_acc_reg <= 1'b0;
      date_acc_reg <= 1'b0;
      dow_acc_reg  <= 1'b0;
      time_acc_reg <= 1'b0;
    end else if (valid) begin
      if (in_range(sec, YEAR_LO, YEAR_HI)) year_acc_reg <= year_acc_reg ^ a;
      if (in_range(sec, DATE_LO, DATE_HI)) date_acc_reg <= date_acc_reg ^ a;
      if (in_range(sec, DOW_LO, DOW_HI))   dow_acc_reg  <= dow_acc_reg ^ a;
      if (in_range(sec, TIME_LO, TIME_HI)) time_acc_reg <= time_acc_reg ^ a;
    end
  end

  // one capture flop per parity bit, index 0 = 54B
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bcap
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          b_cap_reg[gi] <= 1'b0;
        end else if (valid && (sec == 6'(PAR_LO + gi))) begin
          b_cap_reg[gi] <= b;
        end
      end
    end
  endgenerate

  assign year_ok = year_acc_reg ^ b_cap_reg[0];
  assign date_ok = date_acc_reg ^ b_cap_reg[1];
  assign dow_ok  = dow_acc_reg  ^ b_cap_reg[2];
  assign time_ok = time_acc_reg ^ b_cap_reg[3];

endmodule

// File: rtl/msf_frame_validator.sv
// msf_frame_validator: tracks the second index of the MSF symbol stream,
// checks the 52A..59A minute identifier and the 54B..57B parities, and
// pulses frame_ok_o at the minute marker closing a fully valid frame.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   bits_valid_i           : strobe, new second symbol
//   bits_is_second_00_i    : symbol is the minute marker
//   bits_data_i            : [1]=A, [0]=B
//   second_o               : current second (0 in HUNT, LAST_SECOND while armed)
//   frame_ok_o/frame_err_o : one-cycle result pulses
//   err_code_o             : last rejection cause (held)
//   locked_o               : LOCK_FRAMES consecutive good frames seen
// Optional macro MSF_FRAME_STATS_EN adds good_count_o / err_count_o
// (saturating 8-bit frame counters).
module msf_frame_validator
  import msf_pkg::*;
#(
  parameter int LOCK_FRAMES = 2,
  parameter int LAST_SECOND = 59
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       bits_valid_i,
  input  logic       bits_is_second_00_i,
  input  logic [1:0] bits_data_i,
  output logic [5:0] second_o,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [2:0] err_code_o,
`ifdef MSF_FRAME_STATS_EN
  output logic [7:0] good_count_o,
  output logic [7:0] err_count_o,
`endif
  output logic       locked_o
);

  localparam logic [3:0] LOCK_VAL = 4'(LOCK_FRAMES);
  localparam logic [5:0] LAST_SEC = 6'(LAST_SECOND);

  state_t     state_reg,  state_next;
  logic [5:0] sec_reg,    sec_next;
  logic       ok_reg,     ok_next;
  logic       err_reg,    err_next;
  err_code_t  code_reg,   code_next;
  logic [3:0] good_reg,   good_next;
  logic [6:0] marker_reg, marker_next;   // 52A..58A, oldest in bit 6

  logic       acc_valid, acc_clear;
  logic [5:0] sec_inc;
  logic       year_ok, date_ok, dow_ok, time_ok;
  err_code_t  check_code;
  logic       marker_sym, a_bit;

  assign marker_sym = bits_is_second_00_i;
  assign a_bit      = bits_data_i[1];
  assign sec_inc    = sec_reg + 6'd1;

  msf_parity_acc u_parity_acc (
    .clk     (clk_i),
    .rst     (rst_i),
    .sec     (sec_inc),
    .a       (bits_data_i[1]),
    .b       (bits_data_i[0]),
    .valid   (acc_valid),
    .clear   (acc_clear),
    .year_ok (year_ok),
    .date_ok (date_ok),
    .dow_ok  (dow_ok),
    .time_ok (time_ok)
  );

  // Evaluated on the final second: the current A bit completes the identifier.
  always_comb begin
    check_code = ERR_NONE;
    if ({marker_reg, a_bit} != MARKER_PATTERN) check_code = ERR_MARKER;
    else if (!year_ok)                         check_code = ERR_PAR_YEAR;
    else if (!date_ok)                         check_code = ERR_PAR_DATE;
    else if (!dow_ok)                          check_code = ERR_PAR_DOW;
    else if (!time_ok)                         check_code = ERR_PAR_TIME;
  end

  always_comb begin
    state_next  = state_reg;
    sec_next    = sec_reg;
    ok_next     = 1'b0;
    err_next    = 1'b0;
    code_next   = code_reg;
    good_next   = good_reg;
    marker_next = marker_reg;
    acc_valid   = 1'b0;
    acc_clear   = 1'b0;
    if (bits_valid_i) begin
      case (state_reg)
        HUNT: begin
          if (marker_sym) begin
            state_next  = COLLECT;
            sec_next    = 6'd0;
            acc_clear   = 1'b1;
            marker_next = '0;
          end
        end
        COLLECT: begin
          if (marker_sym) begin
            // early marker: reject, and treat it as second 00 of a new frame
            err_next    = 1'b1;
            code_next   = ERR_SHORT;
            good_next   = 4'd0;
            sec_next    = 6'd0;
            acc_clear   = 1'b1;
            marker_next = '0;
          end else begin
            sec_next  = sec_inc;
            acc_valid = 1'b1;
            if (in_range(sec_inc, MARKER_LO, MARKER_HI - 1))
              marker_next = {marker_reg[5:0], a_bit};
            if (sec_inc == LAST_SEC) begin
              if (check_code != ERR_NONE) begin
                err_next   = 1'b1;
                code_next  = check_code;
                good_next  = 4'd0;
                sec_next   = 6'd0;
                state_next = HUNT;
              end else begin
                state_next = ARMED;
              end
            end
          end
        end
        ARMED: begin
          if (marker_sym) begin
            ok_next     = 1'b1;
            state_next  = COLLECT;
            sec_next    = 6'd0;
            acc_clear   = 1'b1;
            marker_next = '0;
            if (good_reg != LOCK_VAL) good_next = good_reg + 4'd1;
          end else begin
            err_next   = 1'b1;
            code_next  = ERR_LONG;
            good_next  = 4'd0;
            sec_next   = 6'd0;
            state_next = HUNT;
          end
        end
        default: begin
          state_next = HUNT;
          sec_next   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= HUNT;
      sec_reg    <= 6'd0;
      ok_reg     <= 1'b0;
      err_reg    <= 1'b0;
      code_reg   <= ERR_NONE;
      good_reg   <= 4'd0;
      marker_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sec_reg    <= sec_next;
      ok_reg     <= ok_next;
      err_reg    <= err_next;
      code_reg   <= code_next;
      good_reg   <= good_next;
      marker_reg <= marker_next;
    end
  end

`ifdef MSF_FRAME_STATS_EN
  logic [7:0] good_cnt_reg, err_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      good_cnt_reg <= 8'd0;
      err_cnt_reg  <= 8'd0;
    end else begin
      if (ok_next && (good_cnt_reg != 8'hFF)) good_cnt_reg <= good_cnt_reg + 8'd1;
      if (err_next && (err_cnt_reg != 8'hFF)) err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign good_count_o = good_cnt_reg;
  assign err_count_o  = err_cnt_reg;
`endif

  assign second_o    = sec_reg;
  assign frame_ok_o  = ok_reg;
  assign frame_err_o = err_reg;
  assign err_code_o  = code_reg;
  assign locked_o    = (good_reg == LOCK_VAL);

endmodule

// File: tb/tb_msf_frame_validator.sv
// tb_msf_frame_validator: table-driven, directed and randomized checks of
// msf_frame_validator against a frame-level reference model.
`timescale 1ns/1ps
module tb_msf_frame_validator;

  localparam int LOCK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       is00 = 1'b0;
  logic [1:0] data = 2'b00;
  logic [5:0] sec;
  logic       ok, err, locked;
  logic [2:0] code;
`ifdef MSF_FRAME_STATS_EN
  logic [7:0] gcnt, ecnt;
`endif

  always #5 clk = ~clk;

  msf_frame_validator #(.LOCK_FRAMES(LOCK), .LAST_SECOND(59)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .bits_valid_i        (valid),
    .bits_is_second_00_i (is00),
    .bits_data_i         (data),
    .second_o            (sec),
    .frame_ok_o          (ok),
    .frame_err_o         (err),
    .err_code_o          (code),
`ifdef MSF_FRAME_STATS_EN
    .good_count_o        (gcnt),
    .err_count_o         (ecnt),
`endif
    .locked_o            (locked)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model (frame level) ----------------
  int m_pos = -1;     // -1 hunting, else index of last symbol received
  bit m_armed = 0;
  int m_good = 0;
  int e_code = 0;
  bit e_ok = 0, e_err = 0;
  bit m_a[60], m_b[60];
  int m_gstat = 0, m_estat = 0;

  // stimulus frame under construction
  bit fa[60], fb[60];

  function automatic int frame_check();
    bit pat[8];
    bit p;
    pat = '{0, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 8; i++) if (m_a[52 + i] != pat[i]) return 3;
    p = m_b[54]; for (int i = 17; i <= 24; i++) p ^= m_a[i]; if (!p) return 4;
    p = m_b[55]; for (int i = 25; i <= 35; i++) p ^= m_a[i]; if (!p) return 5;
    p = m_b[56]; for (int i = 36; i <= 38; i++) p ^= m_a[i]; if (!p) return 6;
    p = m_b[57]; for (int i = 39; i <= 51; i++) p ^= m_a[i]; if (!p) return 7;
    return 0;
  endfunction

  task automatic model_reject(int c);
    e_err = 1; e_code = c; m_good = 0;
    if (m_estat < 255) m_estat++;
  endtask

  task automatic model_step(bit mk, bit a, bit b);
    int c;
    e_ok = 0; e_err = 0;
    if (mk) begin
      if (m_armed) begin
        e_ok = 1;
        if (m_good < LOCK) m_good++;
        if (m_gstat < 255) m_gstat++;
      end else if (m_pos >= 0) begin
        model_reject(1);
      end
      m_pos = 0; m_armed = 0;
    end else if (m_armed) begin
      model_reject(2);
      m_pos = -1; m_armed = 0;
    end else if (m_pos >= 0) begin
      m_pos++;
      m_a[m_pos] = a; m_b[m_pos] = b;
      if (m_pos == 59) begin
        c = frame_check();
        if (c != 0) begin model_reject(c); m_pos = -1; end
        else m_armed = 1;
      end
    end
  endtask

  task automatic model_reset();
    m_pos = -1; m_armed = 0; m_good = 0; e_code = 0; e_ok = 0; e_err = 0;
    m_gstat = 0; m_estat = 0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, " frame_ok"}, int'(ok), int'(e_ok));
    chk({tag, " frame_err"}, int'(err), int'(e_err));
    chk({tag, " err_code"}, int'(code), e_code);
    chk({tag, " second"}, int'(sec), (m_pos < 0) ? 0 : m_pos);
    chk({tag, " locked"}, int'(locked), (m_good == LOCK) ? 1 : 0);
`ifdef MSF_FRAME_STATS_EN
    chk({tag, " good_count"}, int'(gcnt), m_gstat);
    chk({tag, " err_count"}, int'(ecnt), m_estat);
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic send(bit mk, bit [1:0] d);
    @(negedge clk);
    valid = 1'b1; is00 = mk; data = d;
    @(posedge clk);
    model_step(mk, d[1], d[0]);
    #1;
    check_model("sym");
    valid = 1'b0; is00 = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0; is00 = 1'($urandom); data = 2'($urandom);  // marker without valid is ignored
    @(posedge clk);
    e_ok = 0; e_err = 0;
    #1;
    check_model("idle");
    is00 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; is00 = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check_model("reset");
    chk("reset sec_zero", int'(sec), 0);
    chk("reset ok_zero", int'(ok), 0);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // lays out A bits MSB first in each field, sets odd parity on 54B..57B
  task automatic build_frame(int yy, int mo, int dd, int dow, int hh, int mi);
    logic [7:0] y, m, d, h, n;
    bit p;
    for (int i = 0; i < 60; i++) begin fa[i] = 0; fb[i] = 0; end
    y = bcd(yy); m = bcd(mo); d = bcd(dd); h = bcd(hh); n = bcd(mi);
    for (int i = 0; i < 8; i++) fa[17 + i] = y[7 - i];
    for (int i = 0; i < 5; i++) fa[25 + i] = m[4 - i];
    for (int i = 0; i < 6; i++) fa[30 + i] = d[5 - i];
    for (int i = 0; i < 3; i++) fa[36 + i] = 1'((dow >> (2 - i)) & 1);
    for (int i = 0; i < 6; i++) fa[39 + i] = h[5 - i];
    for (int i = 0; i < 7; i++) fa[45 + i] = n[6 - i];
    for (int i = 53; i <= 58; i++) fa[i] = 1;
    p = 1; for (int i = 17; i <= 24; i++) p ^= fa[i]; fb[54] = p;
    p = 1; for (int i = 25; i <= 35; i++) p ^= fa[i]; fb[55] = p;
    p = 1; for (int i = 36; i <= 38; i++) p ^= fa[i]; fb[56] = p;
    p = 1; for (int i = 39; i <= 51; i++) p ^= fa[i]; fb[57] = p;
  endtask

  task automatic send_body(int n, bit gaps);
    for (int s = 1; s <= n; s++) begin
      if (gaps && ($urandom_range(0, 7) == 0)) idle();
      send(1'b0, {fa[s], fb[s]});
    end
  endtask

  // ---------------- table of short HUNT / early-marker vectors ----------------
  typedef struct {
    bit       mk;
    bit [1:0] d;
    bit       x_ok;
    bit       x_err;
    bit [2:0] x_code;
    int       x_sec;
  } vec_t;

  vec_t tbl[9];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int kind, n;
    tbl[0] = '{0, 2'b11, 0, 0, 3'd0, 0};  // HUNT ignores data
    tbl[1] = '{1, 2'b00, 0, 0, 3'd0, 0};  // marker starts collection
    tbl[2] = '{0, 2'b11, 0, 0, 3'd0, 1};
    tbl[3] = '{0, 2'b01, 0, 0, 3'd0, 2};
    tbl[4] = '{1, 2'b00, 0, 1, 3'd1, 0};  // early marker -> SHORT
    tbl[5] = '{0, 2'b10, 0, 0, 3'd1, 1};  // marker reused, code held
    tbl[6] = '{1, 2'b00, 0, 1, 3'd1, 0};
    tbl[7] = '{1, 2'b00, 0, 1, 3'd1, 0};  // back-to-back markers
    tbl[8] = '{0, 2'b00, 0, 0, 3'd1, 1};

    repeat (2) @(posedge clk);
    do_reset();
    chk("reset code", int'(code), 0);
    chk("reset locked", int'(locked), 0);

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].mk, tbl[i].d);
      chk($sformatf("tbl%0d ok", i), int'(ok), int'(tbl[i].x_ok));
      chk($sformatf("tbl%0d err", i), int'(err), int'(tbl[i].x_err));
      chk($sformatf("tbl%0d code", i), int'(code), int'(tbl[i].x_code));
      chk($sformatf("tbl%0d sec", i), int'(sec), tbl[i].x_sec);
    end
    $display("table: 9 vectors applied");

    // good frame 23-03-15 Wed 14:37
    do_reset();
    build_frame(23, 3, 15, 3, 14, 37);
    send(1'b1, 2'b00);
    send_body(59, 0);
    chk("good armed sec", int'(sec), 59);
    send(1'b1, 2'b00);
    chk("good ok", int'(ok), 1);
    chk("good code", int'(code), 0);
    chk("good sec", int'(sec), 0);
    chk("good locked1", int'(locked), 0);
    $display("frame: good 23-03-15 Wed 14:37");

    send_body(59, 0);
    send(1'b1, 2'b00);
    chk("lock ok", int'(ok), 1);
    chk("lock locked", int'(locked), 1);
    $display("frame: second good frame, lock");

    fb[55] ^= 1;
    send_body(59, 0);
    chk("pardate err", int'(err), 1);
    chk("pardate code", int'(code), 5);
    chk("pardate locked", int'(locked), 0);
    fb[55] ^= 1;
    $display("frame: 55B flipped");

    send(1'b1, 2'b00);
    send_body(40, 0);
    send(1'b1, 2'b00);
    chk("short err", int'(err), 1);
    chk("short code", int'(code), 1);
    chk("short sec", int'(sec), 0);
    send_body(59, 0);
    send(1'b1, 2'b00);
    chk("after short ok", int'(ok), 1);
    $display("frame: short then good");

    send_body(59, 0);
    send(1'b0, 2'b00);
    chk("long err", int'(err), 1);
    chk("long code", int'(code), 2);
    chk("long sec", int'(sec), 0);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 2'b11);
      chk("hunt no_err", int'(err), 0);
      chk("hunt no_ok", int'(ok), 0);
    end
    $display("frame: 61-second minute");

    fa[53] = 0; fb[54] ^= 1;
    send(1'b1, 2'b00);
    send_body(59, 0);
    chk("prio err", int'(err), 1);
    chk("prio code", int'(code), 3);
    fa[53] = 1; fb[54] ^= 1;
    $display("frame: marker and parity both bad");

    send(1'b1, 2'b00);
    send_body(30, 0);
    chk("pre-reset sec", int'(sec), 30);
    do_reset();
    chk("midreset err", int'(err), 0);
    chk("midreset code", int'(code), 0);
    send(1'b1, 2'b00);
    chk("post-reset no_ok", int'(ok), 0);
    send_body(59, 0);
    send(1'b1, 2'b00);
    chk("post-reset ok", int'(ok), 1);
    $display("frame: reset mid-frame");

    // randomized frames, all checked against the model
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 6);
      build_frame($urandom_range(0, 99), $urandom_range(1, 12), $urandom_range(1, 31),
                  $urandom_range(0, 6), $urandom_range(0, 23), $urandom_range(0, 59));
      for (int i = 1; i <= 16; i++) begin fa[i] = 1'($urandom); fb[i] = 1'($urandom); end
      case (kind)
        2: fa[$urandom_range(52, 59)] ^= 1;
        3: if ($urandom_range(0, 1) == 1) fb[$urandom_range(54, 57)] ^= 1;
           else fa[$urandom_range(17, 51)] ^= 1;
        default: ;
      endcase
      if (kind == 6) begin
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) send(1'($urandom_range(0, 3) == 0), 2'($urandom));
      end else begin
        send(1'b1, 2'b00);
        send_body((kind == 4) ? $urandom_range(0, 58) : 59, 1);
        if (kind == 5) send(1'b0, 2'($urandom));
      end
      if ($urandom_range(0, 1) == 1) idle();
      $display("random frame %0d kind %0d: sec=%0d code=%0d locked=%0d", f, kind, sec, code, locked);
    end
    send(1'b1, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
